// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator encodings, response status codes
// and the dispatch controller state encoding.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_OVERFLOW = 2'b01,
        ST_BAD_OP   = 2'b10,
        ST_TIMEOUT  = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } disp_state_t;

    // Only the three one-hot encodings are legal operators
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Bundle of request, response and arithmetic-unit signals around alu_dispatch.
// The slave modport is the controller's view; master is the surrounding system.
interface alu_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] add_in1;
    logic [WIDTH-1:0] add_in2;
    logic             add_sub;
    logic             add_start;
    logic [WIDTH-1:0] add_out;
    logic             add_finish;

    logic [WIDTH-1:0] mul_in1;
    logic [WIDTH-1:0] mul_in2;
    logic             mul_start;
    logic [WIDTH-1:0] mul_out;
    logic             mul_finish;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [1:0]       rsp_status;
    logic             busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  add_out, add_finish, mul_out, mul_finish, rsp_ready,
        output req_ready, add_in1, add_in2, add_sub, add_start,
        output mul_in1, mul_in2, mul_start,
        output rsp_valid, rsp_result, rsp_status, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output add_out, add_finish, mul_out, mul_finish, rsp_ready,
        input  req_ready, add_in1, add_in2, add_sub, add_start,
        input  mul_in1, mul_in2, mul_start,
        input  rsp_valid, rsp_result, rsp_status, busy
    );

endinterface

// File: rtl/add_ovf_detect.sv
// Two's-complement overflow detector for an adder/subtractor result.
// Purely combinational so it can be shared with other accumulating blocks.
module add_ovf_detect #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    input  logic             sub,
    output logic             ovf
);

    logic sign_a;
    logic sign_b;
    logic sign_r;

    assign sign_a = a[WIDTH-1];
    assign sign_b = b[WIDTH-1];
    assign sign_r = r[WIDTH-1];

    // Subtraction flips the effective sign of b
    assign ovf = sub ? ((sign_a != sign_b) && (sign_r != sign_a))
                     : ((sign_a == sign_b) && (sign_r != sign_a));

endmodule

// File: rtl/alu_dispatch.sv
// Dispatch controller: accepts one operation, starts the selected arithmetic
// unit, waits for its finish with a timeout and returns result plus status.
module alu_dispatch
    import calc_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         nRST,
    alu_dispatch_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    disp_state_t      state;
    disp_state_t      state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] wait_cnt;
    logic [WIDTH-1:0] result_reg;
    status_t          status_reg;
    logic             rsp_valid_reg;
    logic             add_start_reg;
    logic             mul_start_reg;
    logic             add_sub_reg;
    logic [WIDTH-1:0] add_in1_reg;
    logic [WIDTH-1:0] add_in2_reg;
    logic [WIDTH-1:0] mul_in1_reg;
    logic [WIDTH-1:0] mul_in2_reg;

    logic accept;
    logic unit_finish;
    logic timed_out;
    logic ovf;
    logic is_sub;

    assign is_sub = (op_reg == OP_SUB);

    add_ovf_detect #(.WIDTH(WIDTH)) u_ovf (
        .a   (a_reg),
        .b   (b_reg),
        .r   (bus.add_out),
        .sub (is_sub),
        .ovf (ovf)
    );

    always_ff @(posedge clk) begin
        if (nRST) state <= S_IDLE;
        else      state <= state_next;
    end

    // Only the finish of the unit that was started is ever looked at
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        unit_finish = 1'b0;
        timed_out   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    accept     = 1'b1;
                    state_next = is_valid_op(bus.req_op) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                unit_finish = (op_reg == OP_MUL) ? bus.mul_finish : bus.add_finish;
                if (unit_finish) begin
                    state_next = S_RESP;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Unit operand registers only change when that unit is selected
    always_ff @(posedge clk) begin
        if (nRST) begin
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            wait_cnt      <= '0;
            result_reg    <= '0;
            status_reg    <= ST_OK;
            rsp_valid_reg <= 1'b0;
            add_start_reg <= 1'b0;
            mul_start_reg <= 1'b0;
            add_sub_reg   <= 1'b0;
            add_in1_reg   <= '0;
            add_in2_reg   <= '0;
            mul_in1_reg   <= '0;
            mul_in2_reg   <= '0;
        end else begin
            add_start_reg <= 1'b0;
            mul_start_reg <= 1'b0;
            if (accept) begin
                op_reg <= bus.req_op;
                a_reg  <= bus.req_a;
                b_reg  <= bus.req_b;
                if (!is_valid_op(bus.req_op)) begin
                    result_reg    <= '0;
                    status_reg    <= ST_BAD_OP;
                    rsp_valid_reg <= 1'b1;
                end else if (bus.req_op == OP_MUL) begin
                    mul_start_reg <= 1'b1;
                    mul_in1_reg   <= bus.req_a;
                    mul_in2_reg   <= bus.req_b;
                end else begin
                    add_start_reg <= 1'b1;
                    add_sub_reg   <= (bus.req_op == OP_SUB);
                    add_in1_reg   <= bus.req_a;
                    add_in2_reg   <= bus.req_b;
                end
            end
            if (state == S_ISSUE) wait_cnt <= '0;
            if (state == S_WAIT) begin
                if (unit_finish) begin
                    result_reg    <= (op_reg == OP_MUL) ? bus.mul_out : bus.add_out;
                    status_reg    <= ((op_reg != OP_MUL) && ovf) ? ST_OVERFLOW : ST_OK;
                    rsp_valid_reg <= 1'b1;
                end else if (timed_out) begin
                    result_reg    <= '0;
                    status_reg    <= ST_TIMEOUT;
                    rsp_valid_reg <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if ((state == S_RESP) && bus.rsp_ready) rsp_valid_reg <= 1'b0;
        end
    end

    assign bus.req_ready  = (state == S_IDLE) && !nRST;
    assign bus.busy       = (state != S_IDLE);
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_status = status_reg;
    assign bus.add_start  = add_start_reg;
    assign bus.mul_start  = mul_start_reg;
    assign bus.add_sub    = add_sub_reg;
    assign bus.add_in1    = add_in1_reg;
    assign bus.add_in2    = add_in2_reg;
    assign bus.mul_in1    = mul_in1_reg;
    assign bus.mul_in2    = mul_in2_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed testbench for alu_dispatch; inputs are driven and outputs sampled
// on the falling clock edge, the DUT works on the rising edge.
module tb_alu_dispatch;
    import calc_pkg::*;

    logic clk;
    logic nRST;
    int   checks;
    int   errors;
    int   add_pulses;
    int   mul_pulses;

    alu_dispatch_if #(.WIDTH(16)) bus ();

    alu_dispatch #(.WIDTH(16), .TIMEOUT(8)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.add_start === 1'b1) add_pulses++;
        if (bus.mul_start === 1'b1) mul_pulses++;
    end

    // Present a request for one cycle; returns in the ISSUE/RESP cycle after acceptance
    task send_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task accept_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task test_reset();
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.add_start !== 1'b0 || bus.mul_start !== 1'b0 || bus.rsp_result !== 16'h0 ||
            bus.rsp_status !== 2'b00 || bus.add_in1 !== 16'h0 || bus.mul_in1 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdy=%b vld=%b busy=%b as=%b ms=%b res=%h st=%b expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.busy, bus.add_start, bus.mul_start,
                     bus.rsp_result, bus.rsp_status);
        end
        nRST = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task test_add_overflow();
        int a0, m0;
        a0 = add_pulses;
        m0 = mul_pulses;
        send_req(OP_ADD, 16'h7FFF, 16'h0001);
        checks++;
        if (bus.add_start !== 1'b1 || bus.add_sub !== 1'b0 || bus.add_in1 !== 16'h7FFF ||
            bus.add_in2 !== 16'h0001 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_issue: start=%b sub=%b in1=%h in2=%h busy=%b rdy=%b expected 1 0 7fff 0001 1 0",
                     bus.add_start, bus.add_sub, bus.add_in1, bus.add_in2, bus.busy, bus.req_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_early_valid: got %b expected 0", bus.rsp_valid);
        end
        bus.add_out    = 16'h8000;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.add_finish = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h8000 || bus.rsp_status !== 2'b01) begin
            errors++;
            $display("[TB] FAIL add_ovf_rsp: vld=%b res=%h st=%b expected 1 8000 01",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_status);
        end
        accept_rsp();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_handshake_done: vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.req_ready);
        end
        checks++;
        if (add_pulses - a0 != 1 || mul_pulses - m0 != 0) begin
            errors++;
            $display("[TB] FAIL add_pulse_count: add=%0d mul=%0d expected 1 0", add_pulses - a0, mul_pulses - m0);
        end
    endtask

    task test_sub_backpressure();
        send_req(OP_SUB, 16'h0005, 16'h0009);
        checks++;
        if (bus.add_sub !== 1'b1 || bus.add_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_issue: sub=%b start=%b expected 1 1", bus.add_sub, bus.add_start);
        end
        @(negedge clk);
        bus.add_out    = 16'hFFFC;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.add_finish = 1'b0;
        bus.add_out    = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'hFFFC || bus.rsp_status !== 2'b00 ||
                bus.req_ready !== 1'b0 || bus.add_in1 !== 16'h0005 || bus.add_in2 !== 16'h0009) begin
                errors++;
                $display("[TB] FAIL sub_hold cycle %0d: vld=%b res=%h st=%b rdy=%b in1=%h expected 1 fffc 00 0 0005",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_status, bus.req_ready, bus.add_in1);
            end
            @(negedge clk);
        end
        accept_rsp();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_release: vld=%b expected 0", bus.rsp_valid);
        end
    endtask

    task test_mul_spurious();
        send_req(OP_MUL, 16'h0012, 16'h0003);
        checks++;
        if (bus.mul_start !== 1'b1 || bus.add_start !== 1'b0 || bus.mul_in1 !== 16'h0012 ||
            bus.mul_in2 !== 16'h0003 || bus.add_in1 !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL mul_issue: ms=%b as=%b min1=%h min2=%h ain1=%h expected 1 0 0012 0003 0005",
                     bus.mul_start, bus.add_start, bus.mul_in1, bus.mul_in2, bus.add_in1);
        end
        @(negedge clk);
        bus.add_out    = 16'h1234;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.add_finish = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_spurious_finish: vld=%b expected 0", bus.rsp_valid);
        end
        bus.mul_out    = 16'h0036;
        bus.mul_finish = 1'b1;
        @(negedge clk);
        bus.mul_finish = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0036 || bus.rsp_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mul_rsp: vld=%b res=%h st=%b expected 1 0036 00",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_status);
        end
        accept_rsp();
    endtask

    task test_bad_op();
        int a0, m0;
        a0 = add_pulses;
        m0 = mul_pulses;
        send_req(3'b011, 16'h1111, 16'h2222);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0 || bus.rsp_status !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bad_op_rsp: vld=%b res=%h st=%b expected 1 0000 10",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_status);
        end
        accept_rsp();
        checks++;
        if (add_pulses != a0 || mul_pulses != m0) begin
            errors++;
            $display("[TB] FAIL bad_op_pulses: add=%0d mul=%0d expected 0 0", add_pulses - a0, mul_pulses - m0);
        end
    endtask

    task test_timeout();
        bit early;
        early = 1'b0;
        send_req(OP_ADD, 16'h0001, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (early || bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0 || bus.rsp_status !== 2'b11) begin
            errors++;
            $display("[TB] FAIL timeout_rsp: early=%b vld=%b res=%h st=%b expected 0 1 0000 11",
                     early, bus.rsp_valid, bus.rsp_result, bus.rsp_status);
        end
        accept_rsp();
        early = 1'b0;
        send_req(OP_ADD, 16'h0001, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) early = 1'b1;
        end
        bus.add_out    = 16'h0003;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.add_finish = 1'b0;
        checks++;
        if (early || bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0003 || bus.rsp_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL timeout_finish_wins: early=%b vld=%b res=%h st=%b expected 0 1 0003 00",
                     early, bus.rsp_valid, bus.rsp_result, bus.rsp_status);
        end
        accept_rsp();
    endtask

    task test_reset_mid();
        send_req(OP_MUL, 16'h0004, 16'h0005);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0 || bus.mul_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: rdy=%b busy=%b ms=%b vld=%b expected 0 0 0 0",
                     bus.req_ready, bus.busy, bus.mul_start, bus.rsp_valid);
        end
        nRST = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_ready: got %b expected 1", bus.req_ready);
        end
        bus.mul_out    = 16'h0014;
        bus.mul_finish = 1'b1;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.mul_finish = 1'b0;
        bus.add_finish = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_stale_finish: vld=%b busy=%b rdy=%b expected 0 0 1",
                     bus.rsp_valid, bus.busy, bus.req_ready);
        end
    endtask

    task test_back_to_back();
        send_req(OP_ADD, 16'h0100, 16'h0200);
        @(negedge clk);
        bus.add_out    = 16'h0300;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.add_finish = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_SUB;
        bus.req_a      = 16'h0010;
        bus.req_b      = 16'h0004;
        checks++;
        if (bus.rsp_result !== 16'h0300 || bus.rsp_status !== 2'b00 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first_rsp: res=%h st=%b rdy=%b expected 0300 00 0",
                     bus.rsp_result, bus.rsp_status, bus.req_ready);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.add_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle_gap: rdy=%b vld=%b as=%b expected 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.add_start);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.add_start !== 1'b1 || bus.add_sub !== 1'b1 || bus.add_in1 !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL b2b_second_issue: as=%b sub=%b in1=%h expected 1 1 0010",
                     bus.add_start, bus.add_sub, bus.add_in1);
        end
        @(negedge clk);
        bus.add_out    = 16'h000C;
        bus.add_finish = 1'b1;
        @(negedge clk);
        bus.add_finish = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h000C || bus.rsp_status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_second_rsp: vld=%b res=%h st=%b expected 1 000c 00",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_status);
        end
        accept_rsp();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        add_pulses     = 0;
        mul_pulses     = 0;
        nRST           = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_a      = 16'h0;
        bus.req_b      = 16'h0;
        bus.add_out    = 16'h0;
        bus.add_finish = 1'b0;
        bus.mul_out    = 16'h0;
        bus.mul_finish = 1'b0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_backpressure();
        test_mul_spurious();
        test_bad_op();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
